// File: rtl/seq_nibble_adder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// seq_nibble_adder
//   Multi-cycle adder for the ALU. Operands are captured on an accepted
//   start and summed one DIGIT-bit digit per clock, least-significant digit
//   first, through a registered carry. Sum and flags publish together on the
//   edge entering DONE and hold until the next operation completes.
//
//   Parameters
//     WIDTH  operand/sum width (multiple of DIGIT)
//     DIGIT  bits added per cycle
//
//   Ports
//     clk    clock, rising edge
//     rst    asynchronous active-high reset
//     start  request, sampled only when not busy (IDLE or DONE)
//     a, b   operands, sampled on the accepted start edge
//     cin    carry-in, sampled on the accepted start edge
//     busy   high while digit steps are in progress
//     done   one-cycle pulse, results newly updated
//     sum    a+b+cin mod 2^WIDTH, held between operations
//     cout   carry out of the MSB
//     ovf    two's-complement overflow
//     zero   sum == 0
// ---------------------------------------------------------------------------

// One digit of the ripple: plain DIGIT-bit add with carry in/out.
module seq_nibble_adder_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);
  assign {co, s} = (DIGIT+1)'(a) + (DIGIT+1)'(b) + (DIGIT+1)'(ci);
endmodule

module seq_nibble_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int STEPS = WIDTH / DIGIT;
  // Counter needs at least one bit even for a single-step configuration.
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state, state_nxt;
  logic [STEPS-1:0][DIGIT-1:0]    opa, opb, psum, psum_nxt;
  logic [CW-1:0]                  k;
  logic                           carry;
  logic                           accept, step, last;
  logic [DIGIT-1:0]               dsum;
  logic                           dcarry;
  logic [WIDTH-1:0]               fsum;

  // Single digit adder shared across steps; the current digit is muxed in.
  seq_nibble_adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (opa[k]),
    .b  (opb[k]),
    .ci (carry),
    .s  (dsum),
    .co (dcarry)
  );

  assign last = (k == CW'(STEPS-1));

  // Partial sum with the digit being produced this cycle already merged,
  // so the final step can publish the complete result on the same edge.
  always_comb begin
    psum_nxt    = psum;
    psum_nxt[k] = dsum;
  end
  assign fsum = psum_nxt;

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        // A start here chains directly into the next operation.
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: operand capture, digit stepping, carry chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      psum  <= '0;
      k     <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= b;
      psum  <= '0;
      k     <= '0;
      carry <= cin;
    end else if (step) begin
      psum  <= psum_nxt;
      carry <= dcarry;
      k     <= last ? '0 : k + CW'(1);
    end
  end

  // Published result: touched only on the last step, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (step && last) begin
      sum  <= fsum;
      cout <= dcarry;
      ovf  <= (opa[STEPS-1][DIGIT-1] == opb[STEPS-1][DIGIT-1]) &&
              (fsum[WIDTH-1] != opa[STEPS-1][DIGIT-1]);
      zero <= (fsum == '0);
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
